// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
//
// Contents:
//   seq_state_t    FSM state encoding (ST_RUN=0, ST_FLUSH=1)
//   DEF_RESET_VEC  default PC value during and after reset
//   DEF_TRAP_VEC   default interrupt handler entry address
//   INSN_BYTES     instruction width in bytes (sequential PC increment)
//   word_align()   clears bits [1:0] of an address

package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1
    } seq_state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
    localparam logic [31:0] INSN_BYTES    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_pc_next_sel.sv
// rtl/pc_sequencer_pc_next_sel.sv - combinational next-PC priority mux
//
// Ports:
//   pc_cur      in  32  current PC
//   stall       in  1   hold: select pc_cur
//   in_run      in  1   FSM is in RUN (redirects allowed)
//   take_irq    in  1   interrupt is being taken this cycle
//   eret        in  1   return from handler
//   epc         in  32  saved return PC
//   jmp         in  1   unconditional jump
//   jmp_target  in  32  jump target
//   br_taken    in  1   taken branch
//   br_target   in  32  branch target
//   pc_next     out 32  selected next PC
//   redirect    out 1   a non-sequential target was selected

module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        in_run,
    input  logic        take_irq,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_next,
    output logic        redirect
);

    logic [31:0] pc_seq;

    // Natural 32-bit overflow gives the required wrap to zero.
    assign pc_seq = pc_cur + INSN_BYTES;

    always_comb begin
        pc_next  = pc_seq;
        redirect = 1'b0;
        if (stall) begin
            pc_next = pc_cur;
        end else if (in_run) begin
            // Outside RUN (flush shadow) every redirect input is ignored.
            if (take_irq) begin
                pc_next  = word_align(TRAP_VEC);
                redirect = 1'b1;
            end else if (eret) begin
                pc_next  = word_align(epc);
                redirect = 1'b1;
            end else if (jmp) begin
                pc_next  = word_align(jmp_target);
                redirect = 1'b1;
            end else if (br_taken) begin
                pc_next  = word_align(br_target);
                redirect = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer with redirect flush FSM and optional interrupt entry
//
// Build option: define PC_SEQ_IRQ_EN to add the irq port, the in_handler flag
// and the interrupt-take path. Without it irq_ack is 0 and epc stays at 0.
//
// Parameters: RESET_VEC (reset PC), TRAP_VEC (handler entry), FLUSH_CYC (1-3)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_cur      in  32       current PC register value
//   stall       in  1        pipeline hold
//   br_taken/br_target       taken branch and target
//   jmp/jmp_target           unconditional jump and target
//   eret        in  1        return from handler
//   irq         in  1        level interrupt request (PC_SEQ_IRQ_EN only)
//   pc_next     out 32       value the PC register loads every clk
//   flush       out 1        squash fetched instruction
//   epc         out 32       saved return PC
//   irq_ack     out 1        pulse when an interrupt is taken
//   state       out 2        FSM state (RUN=0, FLUSH=1)

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int          FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        eret,
`ifdef PC_SEQ_IRQ_EN
    input  logic        irq,
`endif
    output logic [31:0] pc_next,
    output logic        flush,
    output logic [31:0] epc,
    output logic        irq_ack,
    output logic [1:0]  state
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);

    seq_state_t  state_q;
    logic [1:0]  cnt_q;
    logic [31:0] epc_q;
    logic        in_run;
    logic        take_irq;
    logic        redirect;
    logic [31:0] sel_pc_next;

    assign in_run = (state_q == ST_RUN);

`ifdef PC_SEQ_IRQ_EN
    logic in_handler_q;

    // No nesting: a request seen while in the handler, stalled or flushing
    // simply stays pending on the level-sensitive input.
    assign take_irq = irq && !in_handler_q && in_run && !stall && !rst;
`else
    assign take_irq = 1'b0;
`endif

    pc_next_sel #(
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .pc_cur     (pc_cur),
        .stall      (stall),
        .in_run     (in_run),
        .take_irq   (take_irq),
        .eret       (eret),
        .epc        (epc_q),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc_next    (sel_pc_next),
        .redirect   (redirect)
    );

    // Reset masks the registered outputs combinationally so a reset asserted
    // mid-flush or mid-handler takes effect in the very same cycle.
    assign pc_next = rst ? RESET_VEC : sel_pc_next;
    assign flush   = !rst && (state_q == ST_FLUSH);
    assign state   = rst ? 2'(ST_RUN) : 2'(state_q);
    assign epc     = rst ? 32'h0 : epc_q;
    assign irq_ack = take_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            epc_q   <= 32'h0;
`ifdef PC_SEQ_IRQ_EN
            in_handler_q <= 1'b0;
`endif
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FLUSH_INIT;
                    end
                end
                default: begin
                    // Last flush cycle when the counter reads 1.
                    if (cnt_q <= 2'd1) begin
                        state_q <= ST_RUN;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
            endcase
`ifdef PC_SEQ_IRQ_EN
            if (take_irq) begin
                epc_q        <= word_align(pc_cur);
                in_handler_q <= 1'b1;
            end else if (in_run && eret) begin
                in_handler_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        eret;
`ifdef PC_SEQ_IRQ_EN
    logic        irq;
`endif
    logic [31:0] pc_next;
    logic        flush;
    logic [31:0] epc;
    logic        irq_ack;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .FLUSH_CYC (FC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_cur     (pc_cur),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .eret       (eret),
`ifdef PC_SEQ_IRQ_EN
        .irq        (irq),
`endif
        .pc_next    (pc_next),
        .flush      (flush),
        .epc        (epc),
        .irq_ack    (irq_ack),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0; eret = 0;
`ifdef PC_SEQ_IRQ_EN
        irq = 0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; stall = 1; jmp = 1; jmp_target = 32'h40; pc_cur = 32'h1234;
        step();
        step();
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL rst_pc_next got=%h exp=%h", pc_next, 32'h0); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b exp=0", flush); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL rst_irq_ack got=%b exp=0", irq_ack); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got=%h exp=0", epc); end
        clear_inputs();
    endtask

    task automatic test_sequential();
        pc_cur = 32'h0;
        #1;
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL seq0 got=%h exp=%h", pc_next, 32'h0); end
        step();
        rst = 0; pc_cur = 32'h0;
        #1;
        checks++; if (pc_next !== 32'h4) begin errors++; $display("FAIL seq1 got=%h exp=%h", pc_next, 32'h4); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq1_flush got=%b exp=0", flush); end
        step();
        pc_cur = 32'h4;
        #1;
        checks++; if (pc_next !== 32'h8) begin errors++; $display("FAIL seq2 got=%h exp=%h", pc_next, 32'h8); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq2_flush got=%b exp=0", flush); end
    endtask

    task automatic test_branch();
        step();
        pc_cur = 32'h40; br_taken = 1; br_target = 32'h203;
        #1;
        checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL br_target got=%h exp=%h", pc_next, 32'h200); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush0 got=%b exp=0", flush); end
        step();
        br_taken = 0; pc_cur = 32'h200;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush1 got=%b exp=1", flush); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL br_state1 got=%0d exp=1", state); end
        checks++; if (pc_next !== 32'h204) begin errors++; $display("FAIL br_seq1 got=%h exp=%h", pc_next, 32'h204); end
        step();
        pc_cur = 32'h204;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush2 got=%b exp=1", flush); end
        checks++; if (pc_next !== 32'h208) begin errors++; $display("FAIL br_seq2 got=%h exp=%h", pc_next, 32'h208); end
        step();
        pc_cur = 32'h208;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_end got=%b exp=0", flush); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL br_state_end got=%0d exp=0", state); end
        checks++; if (pc_next !== 32'h20C) begin errors++; $display("FAIL br_run got=%h exp=%h", pc_next, 32'h20C); end
    endtask

    task automatic test_jmp_priority();
        step();
        pc_cur = 32'h300; jmp = 1; jmp_target = 32'h507; br_taken = 1; br_target = 32'h600;
        #1;
        checks++; if (pc_next !== 32'h504) begin errors++; $display("FAIL jmp_over_br got=%h exp=%h", pc_next, 32'h504); end
        step();
        jmp = 0; br_target = 32'h700; pc_cur = 32'h504;
        #1;
        checks++; if (pc_next !== 32'h508) begin errors++; $display("FAIL flush_ignores_br got=%h exp=%h", pc_next, 32'h508); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jmp_flush1 got=%b exp=1", flush); end
        step();
        jmp = 1; jmp_target = 32'h900; pc_cur = 32'h508;
        #1;
        checks++; if (pc_next !== 32'h50C) begin errors++; $display("FAIL flush_ignores_jmp got=%h exp=%h", pc_next, 32'h50C); end
        step();
        jmp = 0; br_taken = 0; pc_cur = 32'h50C;
        #1;
        checks++; if (pc_next !== 32'h510) begin errors++; $display("FAIL jmp_run got=%h exp=%h", pc_next, 32'h510); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jmp_flush_end got=%b exp=0", flush); end
    endtask

    task automatic test_eret();
        step();
        pc_cur = 32'h10; eret = 1; jmp = 1; jmp_target = 32'h400;
        #1;
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL eret_over_jmp got=%h exp=%h", pc_next, 32'h0); end
        step();
        eret = 0; jmp = 0; pc_cur = 32'h0;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got=%b exp=1", flush); end
        step();
        pc_cur = 32'h4;
        step();
        pc_cur = 32'h8;
        #1;
        checks++; if (pc_next !== 32'hC) begin errors++; $display("FAIL eret_run got=%h exp=%h", pc_next, 32'hC); end
    endtask

    task automatic test_stall();
        step();
        stall = 1; pc_cur = 32'h20; jmp = 1; jmp_target = 32'h80;
        #1;
        checks++; if (pc_next !== 32'h20) begin errors++; $display("FAIL stall_run_hold got=%h exp=%h", pc_next, 32'h20); end
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL stall_run_state got=%0d exp=0", state); end
        stall = 0;
        #1;
        checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL stall_jmp got=%h exp=%h", pc_next, 32'h80); end
        step();
        jmp = 0; stall = 1; pc_cur = 32'h80;
`ifdef PC_SEQ_IRQ_EN
        irq = 1;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL stall_flush_hold[%0d] got=%h exp=%h", i, pc_next, 32'h80); end
            checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_flush[%0d] got=%b exp=1", i, flush); end
            checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL stall_ack[%0d] got=%b exp=0", i, irq_ack); end
            step();
        end
        stall = 0;
        #1;
        checks++; if (pc_next !== 32'h84) begin errors++; $display("FAIL stall_resume got=%h exp=%h", pc_next, 32'h84); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_cnt_held1 got=%b exp=1", flush); end
        step();
        pc_cur = 32'h84;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_cnt_held2 got=%b exp=1", flush); end
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL stall_ack_flush got=%b exp=0", irq_ack); end
        step();
        pc_cur = 32'h88;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_back_run got=%b exp=0", flush); end
`ifdef PC_SEQ_IRQ_EN
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL stall_pending_ack got=%b exp=1", irq_ack); end
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL stall_pending_trap got=%h exp=%h", pc_next, 32'h100); end
`else
        checks++; if (pc_next !== 32'h8C) begin errors++; $display("FAIL stall_run_seq got=%h exp=%h", pc_next, 32'h8C); end
`endif
    endtask

`ifdef PC_SEQ_IRQ_EN
    task automatic test_irq();
        do_reset();
        pc_cur = 32'h80; irq = 1;
        #1;
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack got=%b exp=1", irq_ack); end
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL irq_trap got=%h exp=%h", pc_next, 32'h100); end
        step();
        irq = 0; pc_cur = 32'h100;
        #1;
        checks++; if (epc !== 32'h80) begin errors++; $display("FAIL irq_epc got=%h exp=%h", epc, 32'h80); end
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_pulse got=%b exp=0", irq_ack); end
        step();
        pc_cur = 32'h104;
        step();
        pc_cur = 32'h108; irq = 1;
        #1;
        checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_nested got=%b exp=0", irq_ack); end
        checks++; if (pc_next !== 32'h10C) begin errors++; $display("FAIL irq_nested_pc got=%h exp=%h", pc_next, 32'h10C); end
        step();
        pc_cur = 32'h10C; eret = 1;
        #1;
        checks++; if (pc_next !== 32'h80) begin errors++; $display("FAIL irq_eret got=%h exp=%h", pc_next, 32'h80); end
        step();
        eret = 0; pc_cur = 32'h80;
        step();
        pc_cur = 32'h84;
        step();
        pc_cur = 32'h88;
        #1;
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL irq_after_eret got=%b exp=1", irq_ack); end
        irq = 0;
    endtask

    task automatic test_irq_eret_coincide();
        do_reset();
        pc_cur = 32'h44; irq = 1; eret = 1;
        #1;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL coincide_trap got=%h exp=%h", pc_next, 32'h100); end
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL coincide_ack got=%b exp=1", irq_ack); end
        step();
        irq = 0; eret = 0; pc_cur = 32'h100;
        #1;
        checks++; if (epc !== 32'h44) begin errors++; $display("FAIL coincide_epc got=%h exp=%h", epc, 32'h44); end
        rst = 1;
        #1;
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_mid_handler_epc got=%h exp=0", epc); end
        step();
        rst = 0; irq = 1; pc_cur = 32'h0;
        #1;
        checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL rst_clears_handler got=%b exp=1", irq_ack); end
        irq = 0;
    endtask
`endif

    task automatic test_wrap_reset();
        do_reset();
        pc_cur = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=%h", pc_next, 32'h0); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL wrap_flush got=%b exp=0", flush); end
        step();
        pc_cur = 32'h0; jmp = 1; jmp_target = 32'h600;
        step();
        jmp = 0; pc_cur = 32'h600;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL pre_rst_flush got=%b exp=1", flush); end
        rst = 1;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_mid_flush got=%b exp=0", flush); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL rst_mid_flush_pc got=%h exp=%h", pc_next, 32'h0); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_mid_flush_state got=%0d exp=0", state); end
        step();
        rst = 0; pc_cur = 32'h0;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL post_rst_flush got=%b exp=0", flush); end
        checks++; if (pc_next !== 32'h4) begin errors++; $display("FAIL post_rst_pc got=%h exp=%h", pc_next, 32'h4); end
    endtask

    initial begin
        rst = 1;
        pc_cur = 32'h0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_jmp_priority();
        test_eret();
        test_stall();
`ifdef PC_SEQ_IRQ_EN
        test_irq();
        test_irq_eret_coincide();
`endif
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, holds the PC value driven during and after reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, holds the interrupt handler entry address.
REQ-003 Parameter FLUSH_CYC, default 1, range 1-3, sets the number of flush cycles after any redirect.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pc_cur  in  32  current PC register output.
REQ-007 stall  in  1  pipeline hold request.
REQ-008 br_taken / br_target  in  1 / 32  taken branch and its target.
REQ-009 jmp / jmp_target  in  1 / 32  unconditional jump and its target.
REQ-010 eret  in  1  return from interrupt handler.
REQ-011 irq  in  1  level interrupt request; present only with IRQ_EN.
REQ-012 pc_next  out  32  value the PC register loads every clk.
REQ-013 flush  out  1  squash the fetched instruction.
REQ-014 epc  out  32  saved return PC.
REQ-015 irq_ack  out  1  one-cycle pulse when an interrupt is taken.
REQ-016 state  out  2  encoded FSM state (RUN=0, FLUSH=1).

Function
REQ-017 pc_next SHALL be combinational from inputs and state; the PC register loads it unconditionally each clk.
REQ-018 With stall=1, pc_next SHALL equal pc_cur, and the FSM, flush counter and epc SHALL hold; an irq arriving during stall stays pending.
REQ-019 In RUN with stall=0, pc_next priority SHALL be: irq-take > eret > jmp > br_taken > pc_cur+4.
REQ-020 pc_cur+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-021 Targets and epc SHALL have bits [1:0] forced to 0.
REQ-022 Any non-sequential selection (irq, eret, jmp, br) SHALL move RUN -> FLUSH and load the counter with FLUSH_CYC.
REQ-023 In FLUSH, flush=1, pc_next=pc_cur+4, and redirect inputs (br, jmp, eret, irq) SHALL be ignored; the counter decrements per unstalled cycle; at 1 it returns to RUN.
REQ-024 flush SHALL be 0 in RUN.
REQ-025 Taking an irq SHALL set epc <= pc_cur, set in_handler, pulse irq_ack and select TRAP_VEC.
REQ-026 An irq SHALL be taken only in RUN with stall=0 and in_handler=0; otherwise it stays pending (no nesting).
REQ-027 eret SHALL select epc and clear in_handler; an eret with in_handler=0 still redirects to epc.
REQ-028 If irq and eret coincide, the irq SHALL win, and the eret SHALL be dropped.

Reset
REQ-029 While rst=1: pc_next=RESET_VEC, state=RUN, flush=0, irq_ack=0, epc=0, in_handler=0, counter=0; rst overrides stall.
REQ-030 Reset asserted mid-FLUSH or mid-handler SHALL abandon that state with no residual flush or pending irq.

Configuration
REQ-031 Macro PC_SEQ_IRQ_EN: when defined, the irq port, the in_handler flag and the irq-take path SHALL exist.
REQ-032 Without PC_SEQ_IRQ_EN: no irq port, irq_ack tied 0, epc still written only by reset, eret still functional.

Structure
REQ-033 A shared package SHALL hold the state enum (RUN, FLUSH), the default vectors RESET_VEC and TRAP_VEC, and the instruction width constant 4.
REQ-034 Next-PC selection SHALL be a sub-module pc_next_sel (pure combinational priority mux); the FSM, counter, epc and flags stay in pc_sequencer.

Verification
REQ-035 rst=1 then release, with no events, pc_cur fed back -> pc_next sequence 0x0, 0x4, 0x8; flush=0 throughout.
REQ-036 br_taken=1, br_target=0x203 at pc_cur=0x40 -> pc_next=0x200, then flush=1 for FLUSH_CYC cycles, then 0x204 in RUN.
REQ-037 jmp=1 and br_taken=1 in the same cycle -> jmp_target selected; the br_taken event during the following FLUSH is ignored.
REQ-038 (IRQ_EN) irq=1 at pc_cur=0x80 -> irq_ack pulse, epc=0x80, pc_next=0x100; a second irq is held until eret; eret -> pc_next=0x80.
REQ-039 stall=1 for 3 cycles during FLUSH with an irq pending -> pc_next=pc_cur, counter held, no irq_ack until RUN with stall=0.
REQ-040 pc_cur=0xFFFF_FFFC with no events -> pc_next=0x0; rst asserted mid-FLUSH -> flush=0 and pc_next=RESET_VEC in the same cycle.
